// File: rtl/ifu_pc_gen_pkg.sv
// rtl/ifu_pc_gen_pkg.sv - shared types and constants for the fetch PC generator
package ifu_pc_gen_pkg;

  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} ifu_state_t;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam int          ILEN_DEFAULT     = 32;

  // No compressed ISA: every fetch address is word aligned.
  function automatic logic [63:0] align_pc(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - fetch PC owner: issues one bus request at a time, hands one instruction to decode
module ifu_pc_gen
  import ifu_pc_gen_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ILEN     = ILEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [63:0]     redirect_target,
  output logic            ireq_valid,
  output logic [63:0]     ireq_addr,
  input  logic            ireq_data_ok,
  input  logic [ILEN-1:0] ireq_data,
  output logic            if_valid,
  output logic [ILEN-1:0] if_inst,
  output logic [63:0]     if_pc,
  input  logic            id_ready
);

  ifu_state_t      state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [63:0]     pend_q, pend_d;
  logic [63:0]     tgt;
  logic            run_q;
  logic            load_inst;
  logic [ILEN-1:0] inst_q;
  logic [63:0]     ipc_q;

  assign tgt = align_pc(redirect_target);

  // run_q delays the first request by one cycle after reset and masks late responses.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    load_inst = 1'b0;
    if (run_q) begin
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            if (ireq_data_ok) begin
              pc_d = tgt;
            end else begin
              pend_d  = tgt;
              state_d = FLUSH;
            end
          end else if (ireq_data_ok) begin
            load_inst = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_d    = tgt;
            state_d = FETCH;
          end else if (id_ready) begin
            pc_d    = pc_q + 64'd4;
            state_d = FETCH;
          end
        end
        FLUSH: begin
          if (ireq_data_ok) begin
            pc_d    = redirect_valid ? tgt : pend_q;
            state_d = FETCH;
          end else if (redirect_valid) begin
            pend_d = tgt;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      run_q   <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      run_q   <= 1'b1;
      if (load_inst) begin
        inst_q <= ireq_data;
        ipc_q  <= pc_q;
      end
    end
  end

  // In FLUSH pc_q still holds the outstanding address; the new target waits in pend_q.
  assign ireq_valid = run_q && (state_q != HOLD);
  assign ireq_addr  = pc_q;
  assign if_valid   = (state_q == HOLD);
  assign if_inst    = inst_q;
  assign if_pc      = ipc_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb/tb_ifu_pc_gen.sv - directed table-driven bench for ifu_pc_gen
module tb_ifu_pc_gen;

  localparam logic [63:0] A = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_data_ok;
  logic [31:0] ireq_data;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        id_ready;

  int checks = 0;
  int errors = 0;

  ifu_pc_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ireq_valid      (ireq_valid),
    .ireq_addr       (ireq_addr),
    .ireq_data_ok    (ireq_data_ok),
    .ireq_data       (ireq_data),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .id_ready        (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        rv;
    logic [63:0] rt;
    logic        dok;
    logic [31:0] dat;
    logic        rdy;
    logic        chk;
    logic        e_iv;
    logic [63:0] e_addr;
    logic        e_fv;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] d(input int n);
    return 32'hA000_0000 + n;
  endfunction

  task automatic v(input logic rn, input logic rv, input logic [63:0] rt,
                   input logic dok, input logic [31:0] dat, input logic rdy,
                   input logic chk, input logic e_iv, input logic [63:0] e_addr,
                   input logic e_fv, input logic [63:0] e_pc, input logic [31:0] e_inst);
    vec_t x;
    x = '{rn, rv, rt, dok, dat, rdy, chk, e_iv, e_addr, e_fv, e_pc, e_inst};
    vecs.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic e_iv, input logic [63:0] e_addr,
                       input logic e_fv, input logic [63:0] e_pc, input logic [31:0] e_inst);
    checks++;
    if (ireq_valid !== e_iv) begin
      errors++;
      $display("FAIL %s ireq_valid got %0b want %0b", name, ireq_valid, e_iv);
    end
    if (e_iv) begin
      checks++;
      if (ireq_addr !== e_addr) begin
        errors++;
        $display("FAIL %s ireq_addr got %h want %h", name, ireq_addr, e_addr);
      end
    end
    checks++;
    if (if_valid !== e_fv) begin
      errors++;
      $display("FAIL %s if_valid got %0b want %0b", name, if_valid, e_fv);
    end
    checks++;
    if (if_pc !== e_pc) begin
      errors++;
      $display("FAIL %s if_pc got %h want %h", name, if_pc, e_pc);
    end
    checks++;
    if (if_inst !== e_inst) begin
      errors++;
      $display("FAIL %s if_inst got %h want %h", name, if_inst, e_inst);
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    ireq_data_ok = 1'b0; ireq_data = '0; id_ready = 1'b0;

    // reset, then sequential fetch with data_ok two cycles after each request
    v(0,0,0,0,0,0, 0, 0,0,0,0,0);
    v(0,0,0,0,0,0, 1, 0,0,0,0,0);
    v(1,0,0,0,0,0, 1, 0,0,0,0,0);
    v(1,0,0,0,0,1, 1, 1,A,0,0,0);
    v(1,0,0,0,0,1, 1, 1,A,0,0,0);
    v(1,0,0,1,d(0),1, 1, 1,A,0,0,0);
    v(1,0,0,0,0,1, 1, 0,0,1,A,d(0));
    v(1,0,0,0,0,1, 1, 1,A+4,0,A,d(0));
    v(1,0,0,0,0,1, 1, 1,A+4,0,A,d(0));
    v(1,0,0,1,d(1),1, 1, 1,A+4,0,A,d(0));
    v(1,0,0,0,0,1, 1, 0,0,1,A+4,d(1));
    v(1,0,0,0,0,1, 1, 1,A+8,0,A+4,d(1));
    v(1,0,0,0,0,1, 1, 1,A+8,0,A+4,d(1));
    v(1,0,0,1,d(2),1, 1, 1,A+8,0,A+4,d(1));
    v(1,0,0,0,0,1, 1, 0,0,1,A+8,d(2));
    // redirect in FETCH, response three cycles later is discarded
    v(1,1,A+'h100,0,0,0, 1, 1,A+12,0,A+8,d(2));
    v(1,0,0,0,0,0, 1, 1,A+12,0,A+8,d(2));
    v(1,0,0,0,0,0, 1, 1,A+12,0,A+8,d(2));
    v(1,0,0,1,d(3),0, 1, 1,A+12,0,A+8,d(2));
    v(1,0,0,0,0,0, 1, 1,A+'h100,0,A+8,d(2));
    // redirect coincident with data_ok
    v(1,1,A+'h200,1,d(4),0, 1, 1,A+'h100,0,A+8,d(2));
    // enter FLUSH, then two more redirects: youngest wins
    v(1,1,A+'h250,0,0,0, 1, 1,A+'h200,0,A+8,d(2));
    v(1,1,A+'h300,0,0,0, 1, 1,A+'h200,0,A+8,d(2));
    v(1,1,A+'h400,0,0,0, 1, 1,A+'h200,0,A+8,d(2));
    v(1,0,0,1,d(5),0, 1, 1,A+'h200,0,A+8,d(2));
    v(1,0,0,0,0,0, 1, 1,A+'h400,0,A+8,d(2));
    v(1,0,0,1,d(6),0, 1, 1,A+'h400,0,A+8,d(2));
    // misaligned redirect in HOLD with id_ready=1
    v(1,1,A+'h102,0,0,1, 1, 0,0,1,A+'h400,d(6));
    v(1,0,0,0,0,0, 1, 1,A+'h100,0,A+'h400,d(6));
    v(1,0,0,1,d(7),0, 1, 1,A+'h100,0,A+'h400,d(6));
    v(1,0,0,0,0,0, 1, 0,0,1,A+'h100,d(7));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst_n           = vecs[i].rn;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      ireq_data_ok    = vecs[i].dok;
      ireq_data       = vecs[i].dat;
      id_ready        = vecs[i].rdy;
      if (vecs[i].chk)
        check($sformatf("vec%0d", i), vecs[i].e_iv, vecs[i].e_addr,
              vecs[i].e_fv, vecs[i].e_pc, vecs[i].e_inst);
      step();
    end

    // decode stalls for five cycles: held instruction stays put, no request
    redirect_valid = 1'b0; ireq_data_ok = 1'b0; id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d", k), 1'b0, '0, 1'b1, A+'h100, d(7));
      step();
    end
    id_ready = 1'b1;
    check("stall_release", 1'b0, '0, 1'b1, A+'h100, d(7));
    step();
    id_ready = 1'b0;
    check("after_accept", 1'b1, A+'h104, 1'b0, A+'h100, d(7));

    // reset in the middle of FLUSH, then a late response must be ignored
    redirect_valid = 1'b1; redirect_target = A+'h500;
    step();
    redirect_valid = 1'b0;
    check("flush_hold_addr", 1'b1, A+'h104, 1'b0, A+'h100, d(7));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; ireq_data_ok = 1'b1; ireq_data = 32'hDEAD_BEEF;
    check("post_reset", 1'b0, '0, 1'b0, '0, '0);
    step();
    ireq_data_ok = 1'b0;
    check("first_req_after_reset", 1'b1, A, 1'b0, '0, '0);
    step();
    check("late_data_ignored", 1'b1, A, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
